alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a power of two, 4..64.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  operation code (REQ-012).
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  operation result.
REQ-011 zf, sf, of, cf, dz  output  1 each  zero, sign, overflow, carry, divide-by-zero flags.

Function
REQ-012 Op codes: 000 ADD a+b; 001 SUB b-a; 010 XOR; 011 ANDN a&~b; 100 ROL a left by b[log2(WIDTH)-1:0]; 101 MUL low WIDTH bits of a*b unsigned; 110 DIVU a/b; 111 REMU a%b.
REQ-013 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept = in_valid & in_ready; operands and op SHALL be captured on accept; later input changes SHALL be ignored.
REQ-015 Ops 000-100: IDLE -> DONE on accept; out_valid SHALL assert the cycle after accept.
REQ-016 Ops 101-111: IDLE -> BUSY on accept; one shift-add/shift-subtract step per cycle for exactly WIDTH cycles; BUSY -> DONE; out_valid SHALL assert WIDTH+1 cycles after accept.
REQ-017 DONE: result and flags SHALL hold stable while out_valid & ~out_ready; on out_valid & out_ready -> IDLE, out_valid deasserts next cycle.
REQ-018 No new request SHALL be accepted in the DONE cycle in which out_ready is sampled; earliest re-accept is the following cycle.
REQ-019 zf = (result == 0); sf = result[WIDTH-1]; valid for every op.
REQ-020 ADD: cf = carry out of bit WIDTH-1; of = signed two's-complement overflow.
REQ-021 SUB: computed as b + ~a + 1; cf = that carry out (1 = no borrow); of = signed overflow.
REQ-022 MUL: of = 1 iff upper WIDTH bits of full 2*WIDTH product nonzero; cf = 0.
REQ-023 XOR, ANDN, ROL, DIVU, REMU: of = 0, cf = 0.
REQ-024 b == 0 on DIVU/REMU: dz = 1, DIVU result all ones, REMU result = a, same WIDTH+1 latency; dz = 0 for all other cases.
REQ-025 Iteration counter SHALL be clog2(WIDTH)+1 bits and SHALL NOT wrap while BUSY.

Reset
REQ-026 rst high at a clk edge SHALL force IDLE, out_valid 0, result 0, all flags 0, counter 0.
REQ-027 rst during BUSY or DONE SHALL abort the operation with no result ever presented; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-028 rst SHALL take priority over any simultaneous accept or output handshake.

Structure
REQ-029 Op-code constants SHALL live in shared include file alu_iter_ops.v, used by block and bench.
REQ-030 Iterative datapath SHALL be sub-module muldiv_iter (start, op select, operands, done, WIDTH-wide product/quotient/remainder); single-cycle ops and FSM SHALL stay in alu_iter.
REQ-031 No combinational path SHALL exist from in_* to out_* or from out_ready to in_ready.

Verification
REQ-032 WIDTH=16, ADD a=0x7FFF b=0x0001 -> out_valid cycle after accept, result 0x8000, of=1, sf=1, cf=0, zf=0.
REQ-033 WIDTH=16, SUB a=0x0005 b=0x0005 -> result 0x0000, zf=1, cf=1, of=0; ROL a=0x8001 b=0x0004 -> result 0x0018.
REQ-034 WIDTH=16, MUL a=0x0100 b=0x0100 -> out_valid exactly 17 cycles after accept, result 0x0000, of=1, zf=1; in_ready 0 throughout.
REQ-035 WIDTH=16, DIVU a=100 b=7 -> result 14; REMU same -> result 2; DIVU b=0 -> result 0xFFFF, dz=1.
REQ-036 Backpressure: out_ready held 0 five cycles after out_valid -> result/flags stable, in_ready 0; out_ready 1 -> IDLE next cycle.
REQ-037 rst asserted mid-MUL (cycle 8 of BUSY) -> no out_valid, in_ready 1 after release; WIDTH=8 rerun of REQ-035 divide -> 9-cycle latency.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared types, op-code constants and op classification helpers for alu_iter.
package alu_iter_pkg;

`include "alu_iter_ops.v"

    localparam logic [2:0] OpAdd  = `ALU_OP_ADD;
    localparam logic [2:0] OpSub  = `ALU_OP_SUB;
    localparam logic [2:0] OpXor  = `ALU_OP_XOR;
    localparam logic [2:0] OpAndn = `ALU_OP_ANDN;
    localparam logic [2:0] OpRol  = `ALU_OP_ROL;
    localparam logic [2:0] OpMul  = `ALU_OP_MUL;
    localparam logic [2:0] OpDivu = `ALU_OP_DIVU;
    localparam logic [2:0] OpRemu = `ALU_OP_REMU;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Ops that go through the multi-cycle datapath.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OpMul) || (op == OpDivu) || (op == OpRemu);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OpDivu) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/alu_iter_ops.v
// Operation codes shared by the alu_iter block and anything that drives it.
`ifndef ALU_ITER_OPS_V
`define ALU_ITER_OPS_V
`define ALU_OP_ADD  3'b000
`define ALU_OP_SUB  3'b001
`define ALU_OP_XOR  3'b010
`define ALU_OP_ANDN 3'b011
`define ALU_OP_ROL  3'b100
`define ALU_OP_MUL  3'b101
`define ALU_OP_DIVU 3'b110
`define ALU_OP_REMU 3'b111
`endif

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle for WIDTH cycles.
module muldiv_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    // hi/lo hold {product_hi, product} for MUL and {remainder, quotient} for DIV.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             div_q, div_d;
    logic             run_q, run_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    assign unused_diff_bit = diff[WIDTH];

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH + 1){1'b0}});
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m_q};

        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        div_d = div_q;
        run_d = run_q;
        cnt_d = cnt_q;

        if (start) begin
            hi_d  = '0;
            lo_d  = div_sel ? a : b;
            m_d   = div_sel ? b : a;
            div_d = div_sel;
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            if (div_q) begin
                // diff MSB set means the trial subtraction borrowed: restore.
                if (!diff[WIDTH+1]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastStep) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            div_q <= div_d;
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the cycle whose edge performs the final step.
    assign done       = run_q && (cnt_q == LastStep);
    assign product    = lo_q;
    assign product_hi = hi_q;
    assign quotient   = lo_q;
    assign remainder  = hi_q;

endmodule

// File: rtl/alu_iter.sv
// ALU with single-cycle add/sub/logic/rotate and iterative mul/divu/remu, valid/ready handshake.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cf,
    output logic             dz
);

    localparam int unsigned ShW = $clog2(WIDTH);

    state_e state_q, state_d;

    logic [2:0]       op_q;
    logic             iter_q;
    logic [WIDTH-1:0] res_q;
    logic             zf_q, sf_q, of_q, cf_q, dz_q;

    logic             accept;
    logic             start;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [ShW-1:0]   rot_amt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_of, alu_cf;

    logic             md_done;
    logic [WIDTH-1:0] md_prod, md_prod_hi, md_quot, md_rem, md_res;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .div_sel    (is_div_op(op)),
        .a          (in_a),
        .b          (in_b),
        .done       (md_done),
        .product    (md_prod),
        .product_hi (md_prod_hi),
        .quotient   (md_quot),
        .remainder  (md_rem)
    );

    // Single-cycle datapath, evaluated on the live inputs and captured on accept.
    always_comb begin
        add_sum = {1'b0, in_a} + {1'b0, in_b};
        sub_sum = {1'b0, in_b} + {1'b0, ~in_a} + {{WIDTH{1'b0}}, 1'b1};
        rot_amt = in_b[ShW-1:0];
        alu_res = '0;
        alu_of  = 1'b0;
        alu_cf  = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_cf  = add_sum[WIDTH];
                alu_of  = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_cf  = sub_sum[WIDTH];
                alu_of  = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != in_b[WIDTH-1]);
            end
            OpXor:   alu_res = in_a ^ in_b;
            OpAndn:  alu_res = in_a & ~in_b;
            // A shift by WIDTH yields zero, so rot_amt == 0 needs no special case.
            OpRol:   alu_res = (in_a << rot_amt) | (in_a >> (WIDTH - 32'(rot_amt)));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    start   = is_iter_op(op);
                    state_d = is_iter_op(op) ? StBusy : StDone;
                end
            end
            StBusy: begin
                if (md_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            iter_q  <= 1'b0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            cf_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op;
                iter_q <= is_iter_op(op);
                res_q  <= alu_res;
                zf_q   <= (alu_res == '0);
                sf_q   <= alu_res[WIDTH-1];
                of_q   <= alu_of;
                cf_q   <= alu_cf;
                dz_q   <= is_div_op(op) && (in_b == '0);
            end
        end
    end

    // Iterative results are read straight from the datapath registers, which hold once done.
    always_comb begin
        if (op_q == OpRemu) begin
            md_res = md_rem;
        end else if (op_q == OpMul) begin
            md_res = md_prod;
        end else begin
            md_res = md_quot;
        end
        result = iter_q ? md_res : res_q;
        zf     = iter_q ? (md_res == '0) : zf_q;
        sf     = iter_q ? md_res[WIDTH-1] : sf_q;
        of     = iter_q ? ((op_q == OpMul) && (md_prod_hi != '0)) : of_q;
        cf     = iter_q ? 1'b0 : cf_q;
        dz     = dz_q;
    end

endmodule
